// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Brief    : Shared state encoding, completion-cause codes and defaults
//             for the serial sequence detector.
//  Revision : 1.0
// ============================================================================
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_WINDOW  = 2'b01;
    localparam logic [1:0] CAUSE_MAXHITS = 2'b10;
    localparam logic [1:0] CAUSE_ABORT   = 2'b11;

    localparam int DEF_PAT_W = 5;

endpackage
`default_nettype wire

// File: rtl/seq_shift_match.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_match
//  Brief    : Serial shift history plus combinational compare of the updated
//             PAT_W-bit window against the target pattern (PAT_W >= 2).
//  Revision : 1.0
// ============================================================================
module seq_shift_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_match
);

    // Only PAT_W-1 past bits need storing; the incoming bit completes the window.
    logic [PAT_W-2:0] r_hist;
    logic [PAT_W-1:0] w_window;

    assign w_window = {r_hist, i_bit};
    assign o_match  = (w_window == i_pattern);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= w_window[PAT_W-2:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_ctrl
//  Brief    : Run-controlled serial pattern detector with window budget,
//             hit limit and abort.
//  Revision : 1.0
// ============================================================================
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int WIN_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic [CNT_W-1:0] cfg_max_hits,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_seq,
    output logic             in_ready,
    output logic             busy,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic             done,
    output logic [1:0]       done_cause
);

    localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    state_t           r_state;
    logic [PAT_W-1:0] r_cfg_pattern;
    logic [WIN_W-1:0] r_cfg_window;
    logic [CNT_W-1:0] r_cfg_max_hits;
    logic [WIN_W-1:0] r_win_cnt;
    logic [FILL_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_busy;
    logic             r_hit;
    logic             r_done;
    logic [1:0]       r_done_cause;

    logic             w_start;
    logic             w_take;
    logic             w_match;
    logic             w_hit;
    logic             w_max_last;
    logic             w_win_last;
    logic             w_fill_last;
    logic [WIN_W-1:0] w_win_next;
    logic [CNT_W-1:0] w_hit_inc;

    assign w_start     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // A bit offered in the abort cycle is dropped, never shifted or counted.
    assign w_take      = r_busy && in_valid && !abort;
    assign w_hit       = w_take && (r_state == ST_RUN) && w_match;
    assign w_hit_inc   = (&r_hit_count) ? r_hit_count : r_hit_count + CNT_W'(1);
    assign w_max_last  = w_hit && (r_cfg_max_hits != '0) && (w_hit_inc == r_cfg_max_hits);
    assign w_win_next  = r_win_cnt + WIN_W'(1);
    assign w_win_last  = (r_cfg_window != '0) && (w_win_next == r_cfg_window);
    assign w_fill_last = (r_fill_cnt == FILL_W'(PAT_W - 2));

    seq_shift_match #(
        .PAT_W (PAT_W)
    ) u_shift_match (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_start),
        .i_shift   (w_take),
        .i_bit     (in_seq),
        .i_pattern (r_cfg_pattern),
        .o_match   (w_match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cfg_pattern  <= '0;
            r_cfg_window   <= '0;
            r_cfg_max_hits <= '0;
            r_win_cnt      <= '0;
            r_fill_cnt     <= '0;
            r_hit_count    <= '0;
            r_busy         <= 1'b0;
            r_hit          <= 1'b0;
            r_done         <= 1'b0;
            r_done_cause   <= CAUSE_NONE;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cfg_wr) begin
                        r_cfg_pattern  <= cfg_pattern;
                        r_cfg_window   <= cfg_window;
                        r_cfg_max_hits <= cfg_max_hits;
                    end
                    if (start) begin
                        r_state      <= ST_PRIME;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_done_cause <= CAUSE_NONE;
                        r_hit_count  <= '0;
                        r_win_cnt    <= '0;
                        r_fill_cnt   <= '0;
                    end
                end
                ST_PRIME, ST_RUN: begin
                    if (abort) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_done_cause <= CAUSE_ABORT;
                    end else if (in_valid) begin
                        r_win_cnt <= w_win_next;
                        if (r_state == ST_PRIME) begin
                            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                        end
                        if (w_hit) begin
                            r_hit       <= 1'b1;
                            r_hit_count <= w_hit_inc;
                        end
                        // Hit limit outranks the window when both land on one bit.
                        if (w_max_last) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_done_cause <= CAUSE_MAXHITS;
                        end else if (w_win_last) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_done_cause <= CAUSE_WINDOW;
                        end else if ((r_state == ST_PRIME) && w_fill_last) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = r_busy;
    assign busy       = r_busy;
    assign hit        = r_hit;
    assign hit_count  = r_hit_count;
    assign done       = r_done;
    assign done_cause = r_done_cause;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_det_ctrl
//  Brief    : Self-checking bench for seq_det_ctrl against a bit-history
//             reference model.
//  Revision : 1.0
// ============================================================================
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int PAT_W = 5;
    localparam int WIN_W = 16;
    localparam int CNT_W = 8;
    localparam int VW    = CNT_W + 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_wr;
    logic [PAT_W-1:0] cfg_pattern;
    logic [WIN_W-1:0] cfg_window;
    logic [CNT_W-1:0] cfg_max_hits;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_seq;
    logic             in_ready;
    logic             busy;
    logic             hit;
    logic [CNT_W-1:0] hit_count;
    logic             done;
    logic [1:0]       done_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .PAT_W (PAT_W),
        .WIN_W (WIN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr       (cfg_wr),
        .cfg_pattern  (cfg_pattern),
        .cfg_window   (cfg_window),
        .cfg_max_hits (cfg_max_hits),
        .start        (start),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_seq       (in_seq),
        .in_ready     (in_ready),
        .busy         (busy),
        .hit          (hit),
        .hit_count    (hit_count),
        .done         (done),
        .done_cause   (done_cause)
    );

    // Reference model: run flag, accepted-bit count and the last PAT_W bits.
    logic [PAT_W-1:0] c_pat;
    int               c_win;
    int               c_max;
    bit               m_active;
    bit               m_done;
    bit               m_hit;
    int               m_hits;
    int               m_nacc;
    logic [1:0]       m_cause;
    bit               m_q[$];

    task automatic model_reset();
        c_pat = '0; c_win = 0; c_max = 0;
        m_active = 0; m_done = 0; m_hit = 0;
        m_hits = 0; m_nacc = 0; m_cause = 2'b00;
        m_q.delete();
    endtask

    task automatic model_finish(input logic [1:0] cause);
        m_active = 0;
        m_done   = 1;
        m_cause  = cause;
    endtask

    task automatic model_edge();
        bit matched;
        int v;
        matched = 0;
        v = 0;
        m_hit = 0;
        if (!m_active) begin
            if (cfg_wr) begin
                c_pat = cfg_pattern;
                c_win = int'(cfg_window);
                c_max = int'(cfg_max_hits);
            end
            if (start) begin
                m_active = 1; m_done = 0; m_cause = 2'b00;
                m_hits = 0; m_nacc = 0;
                m_q.delete();
            end
        end else if (abort) begin
            model_finish(2'b11);
        end else if (in_valid) begin
            m_nacc++;
            m_q.push_back(in_seq);
            if (m_q.size() > PAT_W) void'(m_q.pop_front());
            if (m_q.size() == PAT_W) begin
                foreach (m_q[k]) v = (v << 1) | int'(m_q[k]);
                matched = (v == int'(c_pat));
            end
            if (matched) begin
                m_hit = 1;
                if (m_hits < (1 << CNT_W) - 1) m_hits++;
            end
            if (matched && c_max != 0 && m_hits == c_max) model_finish(2'b10);
            else if (c_win != 0 && m_nacc == c_win) model_finish(2'b01);
        end
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {in_ready, busy, hit, hit_count, done, done_cause};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {m_active, m_active, m_hit, CNT_W'(m_hits), m_done, m_cause};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic configure_start(input logic [PAT_W-1:0] pat, input int win, input int mx);
        cfg_wr = 1'b1; start = 1'b1;
        cfg_pattern = pat; cfg_window = WIN_W'(win); cfg_max_hits = CNT_W'(mx);
        step();
        cfg_wr = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_window_stop();
        logic [9:0] s;
        s = 10'b0110101101;
        configure_start(5'b01101, 10, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_seq = s[9-i];
            step();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL window_stop bit %0d: got %h expected %h", i + 1, dut_vec(), mdl_vec());
            end
            checks++;
            if (hit !== 1'(i == 4 || i == 9)) begin
                errors++; $display("FAIL window_stop_hit bit %0d: got %b expected %b", i + 1, hit, (i == 4 || i == 9));
            end
        end
        in_valid = 1'b0;
        step(); step();
        checks++;
        if ({done, done_cause, hit_count, busy} !== {1'b1, 2'b01, 8'd2, 1'b0}) begin
            errors++; $display("FAIL window_stop_final: got done=%b cause=%b cnt=%0d busy=%b expected 1 01 2 0",
                               done, done_cause, hit_count, busy);
        end
    endtask

    task automatic test_overlap_abort();
        logic [6:0] s;
        s = 7'b1010101;
        configure_start(5'b10101, 0, 0);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_seq = s[6-i];
            step();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL overlap bit %0d: got %h expected %h", i + 1, dut_vec(), mdl_vec());
            end
        end
        abort = 1'b1; in_valid = 1'b1; in_seq = 1'b0;
        step();
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if ({done, done_cause, hit_count, hit} !== {1'b1, 2'b11, 8'd2, 1'b0}) begin
            errors++; $display("FAIL overlap_abort: got done=%b cause=%b cnt=%0d hit=%b expected 1 11 2 0",
                               done, done_cause, hit_count, hit);
        end
    endtask

    task automatic test_max_hits();
        configure_start(5'b11111, 5, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_seq = 1'b1;
            step();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL max_hits bit %0d: got %h expected %h", i + 1, dut_vec(), mdl_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if ({hit, done, done_cause, hit_count} !== {1'b1, 1'b1, 2'b10, 8'd1}) begin
            errors++; $display("FAIL max_hits_cause: got hit=%b done=%b cause=%b cnt=%0d expected 1 1 10 1",
                               hit, done, done_cause, hit_count);
        end
    endtask

    task automatic test_short_window();
        configure_start(5'b00000, 3, 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_seq = 1'b0;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if ({done, done_cause, hit_count} !== {1'b1, 2'b01, 8'd0}) begin
            errors++; $display("FAIL short_window: got done=%b cause=%b cnt=%0d expected 1 01 0",
                               done, done_cause, hit_count);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] s;
        s = 9'b101010101;
        configure_start(5'b10101, 0, 0);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_seq = s[8-i];
            step();
        end
        checks++;
        if ({busy, hit_count} !== {1'b1, 8'd3}) begin
            errors++; $display("FAIL mid_run_hits: got busy=%b cnt=%0d expected 1 3", busy, hit_count);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++; $display("FAIL mid_run_reset: got %h expected %h", dut_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_seq = 1'b0;
            step();
            checks++;
            if (in_ready !== 1'b0 || dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL post_reset_idle cyc %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_start: got in_ready=%b expected 1", in_ready);
        end
        abort = 1'b1; in_valid = 1'b0;
        step();
        abort = 1'b0;
    endtask

    task automatic test_cfg_while_busy();
        logic [9:0] s;
        s = 10'b0110100000;
        configure_start(5'b01101, 0, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_seq = s[9-i];
            if (i == 1) begin
                cfg_wr = 1'b1; start = 1'b1;
                cfg_pattern = 5'b00000; cfg_window = WIN_W'(3); cfg_max_hits = CNT_W'(1);
            end
            step();
            cfg_wr = 1'b0; start = 1'b0;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL cfg_busy bit %0d: got %h expected %h", i + 1, dut_vec(), mdl_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if ({busy, hit_count, done} !== {1'b1, 8'd1, 1'b0}) begin
            errors++; $display("FAIL cfg_busy_final: got busy=%b cnt=%0d done=%b expected 1 1 0", busy, hit_count, done);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_valid_toggle();
        logic [4:0] s;
        int         nhits;
        s = 5'b01101;
        nhits = 0;
        configure_start(5'b01101, 0, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_seq   = (i % 2 == 0) ? s[4 - i/2] : ~s[4 - i/2];
            step();
            if (hit === 1'b1) nhits++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL valid_toggle cyc %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (nhits != 1 || hit_count !== 8'd1) begin
            errors++; $display("FAIL valid_toggle_hits: got pulses=%0d cnt=%0d expected 1 1", nhits, hit_count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            start        = ($urandom_range(0, 9) == 0);
            cfg_wr       = ($urandom_range(0, 5) == 0);
            cfg_pattern  = PAT_W'($urandom);
            cfg_window   = ($urandom_range(0, 3) == 0) ? '0 : WIN_W'($urandom_range(1, 40));
            cfg_max_hits = CNT_W'($urandom_range(0, 3));
            abort        = ($urandom_range(0, 49) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_seq       = 1'($urandom);
            step();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        start = 1'b0; cfg_wr = 1'b0; abort = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cfg_wr = 1'b0; cfg_pattern = '0; cfg_window = '0; cfg_max_hits = '0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_seq = 1'b0;
        model_reset();
        test_reset();
        test_window_stop();
        test_overlap_abort();
        test_max_hits();
        test_short_window();
        test_reset_mid_run();
        test_cfg_while_busy();
        test_valid_toggle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
